// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the 5-stage core's hazard/stall controller:
//   - hazard_state_e : controller FSM states (RUN, LU_STALL, MEM_WAIT)
//   - STG_*          : pipeline stage indices used to address the per-stage
//                      stall/flush vectors
//   - PC_WIDTH       : core-wide program counter width
//   - PERF_W         : width of the performance counters
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

  localparam int PC_WIDTH = 32;
  localparam int PERF_W   = 32;

  localparam int STG_IF     = 0;
  localparam int STG_ID     = 1;
  localparam int STG_EX     = 2;
  localparam int STG_MEM    = 3;
  localparam int STG_WB     = 4;
  localparam int NUM_STAGES = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } hazard_state_e;

endpackage

// File: rtl/pipe_perf_counter.sv
// ---------------------------------------------------------------------------
// pipe_perf_counter
// Free-running enable-increment event counter; wraps on overflow.
// Ports:
//   clk   : core clock
//   rst_n : asynchronous active-low reset, clears the count
//   en    : count this cycle
//   count : current count (PERF_W bits)
// ---------------------------------------------------------------------------
module pipe_perf_counter
  import pipe_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [PERF_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central stall/flush controller of the 5-stage in-order core.
// Event priority per cycle: wb_flush > mem_busy (which also holds any EX
// branch) > ex_br_taken > load-use.
//
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   id_valid, load_flag_rs1/rs2     : load-use hazard inputs from ID
//   ex_br_taken, ex_br_target       : taken branch/jump resolved in EX
//   mem_busy                        : MEM data access still pending
//   wb_flush, wb_flush_pc           : exception/ertn committed in WB
//   stall_if/id/ex/mem              : hold the register feeding that stage
//   flush_id/ex/mem/wb              : bubble into that stage's input register
//   mem_cancel                      : abort outstanding MEM access
//   redirect_valid, redirect_pc     : registered fetch redirect to IF
//   wait_timeout                    : sticky MEM-wait watchdog flag
//   perf_lu_cnt/wait_cnt/flush_cnt  : performance counters
//
// Build option: define PIPE_PERF_CNT_EN to implement the performance
// counters; without it the perf ports are tied to zero.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = PC_WIDTH,
  parameter int MAX_WAIT   = 255,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic                  load_flag_rs1,
  input  logic                  load_flag_rs2,
  input  logic                  ex_br_taken,
  input  logic [ADDR_WIDTH-1:0] ex_br_target,
  input  logic                  mem_busy,
  input  logic                  wb_flush,
  input  logic [ADDR_WIDTH-1:0] wb_flush_pc,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  stall_ex,
  output logic                  stall_mem,
  output logic                  flush_id,
  output logic                  flush_ex,
  output logic                  flush_mem,
  output logic                  flush_wb,
  output logic                  mem_cancel,
  output logic                  redirect_valid,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  wait_timeout,
  output logic [PERF_W-1:0]     perf_lu_cnt,
  output logic [PERF_W-1:0]     perf_wait_cnt,
  output logic [PERF_W-1:0]     perf_flush_cnt
);

  localparam logic [CNT_WIDTH-1:0] WAIT_LIMIT = CNT_WIDTH'(MAX_WAIT);

  hazard_state_e         state, state_next;
  logic [CNT_WIDTH-1:0]  wait_cnt, cnt_next;
  logic                  tmo_set;
  logic                  rd_valid_next;
  logic [ADDR_WIDTH-1:0] rd_pc_next;
  logic [STG_MEM:STG_IF] stall_vec;
  logic [STG_WB:STG_ID]  flush_vec;
  logic                  cancel;

  // Watchdog count saturates at the limit so it can never wrap back to 0.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v >= WAIT_LIMIT) ? v : v + 1'b1;
  endfunction

  always_comb begin
    state_next    = state;
    cnt_next      = wait_cnt;
    tmo_set       = 1'b0;
    rd_valid_next = 1'b0;
    rd_pc_next    = redirect_pc;
    stall_vec     = '0;
    flush_vec     = '0;
    cancel        = 1'b0;

    if (wb_flush) begin
      flush_vec     = '1;
      cancel        = 1'b1;
      rd_valid_next = 1'b1;
      rd_pc_next    = wb_flush_pc;
      state_next    = RUN;
      cnt_next      = '0;
    end else if (mem_busy) begin
      // A taken branch in EX is frozen by stall_ex; its flush and redirect
      // fire on the first cycle the memory access completes.
      stall_vec    = '1;
      flush_vec[STG_WB] = 1'b1;
      state_next   = MEM_WAIT;
      cnt_next     = sat_inc(wait_cnt);
      tmo_set      = (cnt_next == WAIT_LIMIT);
    end else if (ex_br_taken) begin
      flush_vec[STG_ID] = 1'b1;
      flush_vec[STG_EX] = 1'b1;
      rd_valid_next     = 1'b1;
      rd_pc_next        = ex_br_target;
      state_next        = RUN;
      cnt_next          = '0;
    end else if (state != LU_STALL && id_valid && (load_flag_rs1 || load_flag_rs2)) begin
      // In LU_STALL the load has moved to MEM and is forwarded there, so a
      // lingering flag must not re-trigger the stall.
      stall_vec[STG_IF] = 1'b1;
      stall_vec[STG_ID] = 1'b1;
      flush_vec[STG_EX] = 1'b1;
      state_next        = LU_STALL;
      cnt_next          = '0;
    end else begin
      state_next = RUN;
      cnt_next   = '0;
    end

    // Combinational outputs follow reset immediately, not just the state.
    if (!rst_n) begin
      stall_vec = '0;
      flush_vec = '0;
      cancel    = 1'b0;
      tmo_set   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= RUN;
      wait_cnt       <= '0;
      wait_timeout   <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      state          <= state_next;
      wait_cnt       <= cnt_next;
      wait_timeout   <= wait_timeout | tmo_set;
      redirect_valid <= rd_valid_next;
      if (rd_valid_next) begin
        redirect_pc <= rd_pc_next;
      end
    end
  end

  assign stall_if   = stall_vec[STG_IF];
  assign stall_id   = stall_vec[STG_ID];
  assign stall_ex   = stall_vec[STG_EX];
  assign stall_mem  = stall_vec[STG_MEM];
  assign flush_id   = flush_vec[STG_ID];
  assign flush_ex   = flush_vec[STG_EX];
  assign flush_mem  = flush_vec[STG_MEM];
  assign flush_wb   = flush_vec[STG_WB];
  assign mem_cancel = cancel;

`ifdef PIPE_PERF_CNT_EN
  logic lu_evt, wait_evt, flush_evt;

  // Load-use is the only cause that stalls IF without stalling MEM;
  // flush_id marks both branch and WB flush events.
  assign lu_evt    = stall_vec[STG_IF] & ~stall_vec[STG_MEM];
  assign wait_evt  = stall_vec[STG_MEM];
  assign flush_evt = flush_vec[STG_ID];

  pipe_perf_counter u_perf_lu (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (lu_evt),
    .count (perf_lu_cnt)
  );

  pipe_perf_counter u_perf_wait (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (wait_evt),
    .count (perf_wait_cnt)
  );

  pipe_perf_counter u_perf_flush (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (flush_evt),
    .count (perf_flush_cnt)
  );
`else
  assign perf_lu_cnt    = '0;
  assign perf_wait_cnt  = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed bench for pipe_hazard_ctrl (MAX_WAIT = 4). Each step drives the
// inputs after a rising edge, pushes the expected outputs onto a scoreboard
// queue, and pops/compares them at the following falling edge.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]  st;    // {stall_if, stall_id, stall_ex, stall_mem}
    logic [3:0]  fl;    // {flush_id, flush_ex, flush_mem, flush_wb}
    logic        cancel;
    logic        rv;
    logic [31:0] pc;
    logic        tmo;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, load_flag_rs1, load_flag_rs2;
  logic        ex_br_taken, mem_busy, wb_flush;
  logic [31:0] ex_br_target, wb_flush_pc;
  logic        stall_if, stall_id, stall_ex, stall_mem;
  logic        flush_id, flush_ex, flush_mem, flush_wb;
  logic        mem_cancel, redirect_valid, wait_timeout;
  logic [31:0] redirect_pc;
  logic [31:0] perf_lu_cnt, perf_wait_cnt, perf_flush_cnt;

  exp_t  sb[$];
  string tq[$];
  int    n_pass  = 0;
  int    n_total = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .ADDR_WIDTH (32),
    .MAX_WAIT   (4),
    .CNT_WIDTH  (8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_valid       (id_valid),
    .load_flag_rs1  (load_flag_rs1),
    .load_flag_rs2  (load_flag_rs2),
    .ex_br_taken    (ex_br_taken),
    .ex_br_target   (ex_br_target),
    .mem_busy       (mem_busy),
    .wb_flush       (wb_flush),
    .wb_flush_pc    (wb_flush_pc),
    .stall_if       (stall_if),
    .stall_id       (stall_id),
    .stall_ex       (stall_ex),
    .stall_mem      (stall_mem),
    .flush_id       (flush_id),
    .flush_ex       (flush_ex),
    .flush_mem      (flush_mem),
    .flush_wb       (flush_wb),
    .mem_cancel     (mem_cancel),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .wait_timeout   (wait_timeout),
    .perf_lu_cnt    (perf_lu_cnt),
    .perf_wait_cnt  (perf_wait_cnt),
    .perf_flush_cnt (perf_flush_cnt)
  );

  function automatic exp_t mk(input logic [3:0] st, input logic [3:0] fl,
                              input logic c, input logic rv,
                              input logic [31:0] pc, input logic tmo);
    exp_t e;
    e.st = st; e.fl = fl; e.cancel = c; e.rv = rv; e.pc = pc; e.tmo = tmo;
    return e;
  endfunction

  task automatic check_out();
    exp_t        e;
    string       t;
    logic [8:0]  obs_ctl, exp_ctl;
    logic [32:0] obs_rd, exp_rd;
    n_total++;
    assert (sb.size() > 0) n_pass++;
    else $error("FAIL scoreboard_empty observed=0 expected=nonzero");
    if (sb.size() > 0) begin
      e = sb.pop_front();
      t = tq.pop_front();
      obs_ctl = {stall_if, stall_id, stall_ex, stall_mem,
                 flush_id, flush_ex, flush_mem, flush_wb, mem_cancel};
      exp_ctl = {e.st, e.fl, e.cancel};
      n_total++;
      assert (obs_ctl === exp_ctl) n_pass++;
      else $error("FAIL %s_ctl observed=%b expected=%b", t, obs_ctl, exp_ctl);
      obs_rd = {redirect_valid, (redirect_valid === 1'b1) ? redirect_pc : 32'h0};
      exp_rd = {e.rv, e.rv ? e.pc : 32'h0};
      n_total++;
      assert (obs_rd === exp_rd) n_pass++;
      else $error("FAIL %s_redir observed=%h expected=%h", t, obs_rd, exp_rd);
      n_total++;
      assert (wait_timeout === e.tmo) n_pass++;
      else $error("FAIL %s_tmo observed=%b expected=%b", t, wait_timeout, e.tmo);
    end
  endtask

  task automatic chk32(input string t, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", t, obs, expv);
  endtask

  // Drive one cycle of inputs, queue the expectation, compare at negedge.
  task automatic step(input logic idv, input logic r1, input logic r2,
                      input logic br, input logic [31:0] tgt,
                      input logic busy, input logic wf, input logic [31:0] wpc,
                      input exp_t e, input string t);
    id_valid      = idv;
    load_flag_rs1 = r1;
    load_flag_rs2 = r2;
    ex_br_taken   = br;
    ex_br_target  = tgt;
    mem_busy      = busy;
    wb_flush      = wf;
    wb_flush_pc   = wpc;
    sb.push_back(e);
    tq.push_back(t);
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    id_valid = 0; load_flag_rs1 = 0; load_flag_rs2 = 0;
    ex_br_taken = 0; ex_br_target = '0; mem_busy = 0; wb_flush = 0; wb_flush_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(mk(4'b0000, 4'b0000, 0, 0, 0, 0));
    tq.push_back("reset");
    check_out();
    chk32("reset_perf_lu", perf_lu_cnt, 32'd0);
    rst_n = 1'b1;

    // idle, then load-use on rs1 held for two cycles
    step(0,0,0, 0,32'h0, 0, 0,32'h0, mk(4'b0000,4'b0000,0,0,0,0), "idle");
    step(1,1,0, 0,32'h0, 0, 0,32'h0, mk(4'b1100,4'b0100,0,0,0,0), "lu_rs1_c0");
    step(1,1,0, 0,32'h0, 0, 0,32'h0, mk(4'b0000,4'b0000,0,0,0,0), "lu_rs1_c1_guard");
    step(0,0,0, 0,32'h0, 0, 0,32'h0, mk(4'b0000,4'b0000,0,0,0,0), "idle2");
    chk32("perf_lu_after_first", perf_lu_cnt, PERF_ON ? 32'd1 : 32'd0);
    // load-use on rs2, then flag without id_valid
    step(1,0,1, 0,32'h0, 0, 0,32'h0, mk(4'b1100,4'b0100,0,0,0,0), "lu_rs2");
    step(0,0,1, 0,32'h0, 0, 0,32'h0, mk(4'b0000,4'b0000,0,0,0,0), "rs2_no_valid_a");
    step(0,0,1, 0,32'h0, 0, 0,32'h0, mk(4'b0000,4'b0000,0,0,0,0), "rs2_no_valid_b");
    // taken branch
    step(0,0,0, 1,32'h1c000040, 0, 0,32'h0, mk(4'b0000,4'b1100,0,0,0,0), "branch");
    step(0,0,0, 0,32'h0, 0, 0,32'h0, mk(4'b0000,4'b0000,0,1,32'h1c000040,0), "branch_redir");
    step(0,0,0, 0,32'h0, 0, 0,32'h0, mk(4'b0000,4'b0000,0,0,0,0), "branch_after");
    // branch held during a 3-cycle MEM wait
    step(0,0,0, 1,32'h1c000080, 1, 0,32'h0, mk(4'b1111,4'b0001,0,0,0,0), "brwait_c0");
    step(0,0,0, 1,32'h1c000080, 1, 0,32'h0, mk(4'b1111,4'b0001,0,0,0,0), "brwait_c1");
    step(0,0,0, 1,32'h1c000080, 1, 0,32'h0, mk(4'b1111,4'b0001,0,0,0,0), "brwait_c2");
    step(0,0,0, 1,32'h1c000080, 0, 0,32'h0, mk(4'b0000,4'b1100,0,0,0,0), "brwait_c3");
    step(0,0,0, 0,32'h0, 0, 0,32'h0, mk(4'b0000,4'b0000,0,1,32'h1c000080,0), "brwait_redir");
    // priority: wb_flush over branch and mem_busy
    step(0,0,0, 1,32'h1c0000c0, 1, 1,32'h1c008000, mk(4'b0000,4'b1111,1,0,0,0), "prio");
    step(1,1,0, 0,32'h0, 0, 0,32'h0, mk(4'b1100,4'b0100,0,1,32'h1c008000,0), "prio_redir_lu");
    // mem_busy arriving in LU_STALL wins
    step(1,1,0, 0,32'h0, 1, 0,32'h0, mk(4'b1111,4'b0001,0,0,0,0), "lustall_busy");
    step(0,0,0, 0,32'h0, 0, 0,32'h0, mk(4'b0000,4'b0000,0,0,0,0), "idle3");
    // WB flush right behind a branch: WB target is the later redirect
    step(0,0,0, 1,32'h1c0000c0, 0, 0,32'h0, mk(4'b0000,4'b1100,0,0,0,0), "br_then_wb_a");
    step(0,0,0, 0,32'h0, 0, 1,32'h1c00a000, mk(4'b0000,4'b1111,1,1,32'h1c0000c0,0), "br_then_wb_b");
    step(0,0,0, 0,32'h0, 0, 0,32'h0, mk(4'b0000,4'b0000,0,1,32'h1c00a000,0), "br_then_wb_c");
    step(0,0,0, 0,32'h0, 0, 0,32'h0, mk(4'b0000,4'b0000,0,0,0,0), "idle4");
    chk32("perf_lu_mid", perf_lu_cnt, PERF_ON ? 32'd3 : 32'd0);
    chk32("perf_wait_mid", perf_wait_cnt, PERF_ON ? 32'd4 : 32'd0);
    chk32("perf_flush_mid", perf_flush_cnt, PERF_ON ? 32'd5 : 32'd0);

    // watchdog: 6 wait cycles with MAX_WAIT = 4
    for (int i = 0; i < 6; i++) begin
      step(0,0,0, 0,32'h0, 1, 0,32'h0,
           mk(4'b1111,4'b0001,0,0,0,(i >= 4) ? 1'b1 : 1'b0), $sformatf("wdog_c%0d", i));
    end
    step(0,0,0, 0,32'h0, 0, 0,32'h0, mk(4'b0000,4'b0000,0,0,0,1), "wdog_sticky_a");
    step(0,0,0, 0,32'h0, 0, 0,32'h0, mk(4'b0000,4'b0000,0,0,0,1), "wdog_sticky_b");
    chk32("perf_wait_wdog", perf_wait_cnt, PERF_ON ? 32'd10 : 32'd0);

    // asynchronous reset in the middle of a MEM wait
    step(0,0,0, 0,32'h0, 1, 0,32'h0, mk(4'b1111,4'b0001,0,0,0,1), "pre_rst_busy");
    #2;
    rst_n = 1'b0;
    #1;
    sb.push_back(mk(4'b0000, 4'b0000, 0, 0, 0, 0));
    tq.push_back("async_rst");
    check_out();
    chk32("async_rst_perf_lu", perf_lu_cnt, 32'd0);
    chk32("async_rst_perf_wait", perf_wait_cnt, 32'd0);
    chk32("async_rst_perf_flush", perf_flush_cnt, 32'd0);
    @(negedge clk);
    mem_busy = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    step(1,1,0, 0,32'h0, 0, 0,32'h0, mk(4'b1100,4'b0100,0,0,0,0), "lu_after_rst");
    step(1,1,0, 0,32'h0, 0, 0,32'h0, mk(4'b0000,4'b0000,0,0,0,0), "lu_after_rst_guard");
    chk32("perf_lu_after_rst", perf_lu_cnt, PERF_ON ? 32'd1 : 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
